// File: rtl/uart_tx_serializer.sv
// UART transmitter: start bit, MSB-first data, optional even parity, stop bits.
// Internal baud divider, CTS-gated accept, and a timed break frame.
module uart_tx_serializer #(
    parameter int unsigned SYSCLK_RATE = 100000000,
    parameter int unsigned BAUD_RATE   = 9600,
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned PARITY_BIT  = 1,
    parameter int unsigned STOP_BITS   = 2
) (
    input  logic                 SysClk,
    input  logic                 Rst,
    input  logic [DATA_BITS-1:0] Tx_Data,
    input  logic                 Transmit_Start,
    input  logic                 Break_Req,
    input  logic                 CTS,
    output logic                 Tx,
    output logic                 Tx_Busy,
    output logic                 Tx_Done
);

    localparam int unsigned BAUD_DIV = SYSCLK_RATE / BAUD_RATE;
    localparam int unsigned TX_BITS  = 1 + DATA_BITS + PARITY_BIT + STOP_BITS;
    localparam int unsigned MAX_DS   = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
    localparam int unsigned MAX_BITS = (MAX_DS > TX_BITS) ? MAX_DS : TX_BITS;
    localparam int unsigned BIT_W    = $clog2(MAX_BITS + 1);
    localparam int unsigned BAUD_W   = $clog2(BAUD_DIV);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic [BAUD_W-1:0]    baud_q, baud_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 parity_q, parity_d;
    logic                 armed_q, armed_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 baud_wrap;

    always_ff @(posedge SysClk or posedge Rst) begin
        if (Rst) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            armed_q  <= 1'b1;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            armed_q  <= armed_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next state; Tx is derived from the next state so it changes on the same edge.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        armed_d   = armed_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        tx_d      = 1'b1;
        baud_wrap = (baud_q == BAUD_W'(BAUD_DIV - 1));

        if (!Transmit_Start && !Break_Req) begin
            armed_d = 1'b1;
        end
        if (state_q != IDLE) begin
            baud_d = baud_wrap ? '0 : baud_q + BAUD_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (armed_q && CTS && (Transmit_Start || Break_Req)) begin
                    shift_d  = Tx_Data;
                    parity_d = ^Tx_Data;
                    armed_d  = 1'b0;
                    baud_d   = '0;
                    bit_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = Break_Req ? BREAK : START;
                end
            end
            START: begin
                if (baud_wrap) begin
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (baud_wrap) begin
                    shift_d = shift_q << 1;
                    if (bit_q == BIT_W'(DATA_BITS - 1)) begin
                        bit_d   = '0;
                        state_d = (PARITY_BIT != 0) ? PARITY : STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            PARITY: begin
                if (baud_wrap) begin
                    bit_d   = '0;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (baud_wrap) begin
                    if (bit_q == BIT_W'(STOP_BITS - 1)) begin
                        bit_d   = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            BREAK: begin
                if (baud_wrap) begin
                    if (bit_q == BIT_W'(TX_BITS - 1)) begin
                        bit_d   = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        case (state_d)
            START, BREAK: tx_d = 1'b0;
            DATA:         tx_d = shift_d[DATA_BITS-1];
            PARITY:       tx_d = parity_d;
            default:      tx_d = 1'b1;
        endcase
    end

    assign Tx      = tx_q;
    assign Tx_Busy = busy_q;
    assign Tx_Done = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: table of frames plus
// hand-written flow-control, back-to-back and reset sequences.
module tb_uart_tx_serializer;

    localparam int unsigned BD  = 16;
    localparam int unsigned NB  = 12;

    logic       SysClk;
    logic       Rst;
    logic [7:0] Tx_Data;
    logic       Transmit_Start;
    logic       Break_Req;
    logic       CTS;
    logic       Tx;
    logic       Tx_Busy;
    logic       Tx_Done;

    int checks = 0;
    int errors = 0;
    bit exp_q[$];

    uart_tx_serializer #(
        .SYSCLK_RATE(16),
        .BAUD_RATE  (1),
        .DATA_BITS  (8),
        .PARITY_BIT (1),
        .STOP_BITS  (2)
    ) dut (
        .SysClk        (SysClk),
        .Rst           (Rst),
        .Tx_Data       (Tx_Data),
        .Transmit_Start(Transmit_Start),
        .Break_Req     (Break_Req),
        .CTS           (CTS),
        .Tx            (Tx),
        .Tx_Busy       (Tx_Busy),
        .Tx_Done       (Tx_Done)
    );

    initial begin
        SysClk = 1'b0;
        forever #5 SysClk = ~SysClk;
    end

    typedef struct {
        string      name;
        logic [7:0] data;
        bit         brk;
        bit         par;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected line values at the 12 bit centres.
    task automatic push_frame(input logic [7:0] data, input bit par, input bit brk);
        if (brk) begin
            for (int i = 0; i < int'(NB); i++) exp_q.push_back(1'b0);
        end else begin
            exp_q.push_back(1'b0);
            for (int i = 7; i >= 0; i--) exp_q.push_back(data[i]);
            exp_q.push_back(par);
            exp_q.push_back(1'b1);
            exp_q.push_back(1'b1);
        end
    endtask

    // Raise the request and wait (bounded) for the first busy cycle.
    task automatic start_req(input string nm, input logic [7:0] data, input bit brk);
        int n;
        Tx_Data        = data;
        Transmit_Start = 1'b1;
        Break_Req      = brk;
        n = 0;
        @(negedge SysClk);
        while (!Tx_Busy && n < 400) begin
            n++;
            @(negedge SysClk);
        end
        chk({nm, "_busy_start"}, 32'(Tx_Busy), 32'd1);
        chk({nm, "_accept_lat"}, 32'(n), 32'd0);
    endtask

    // Called on the first busy cycle; samples bit centres and checks the frame end.
    task automatic check_frame(input string nm, input bit hold, input int cts_drop,
                               input int rearm_at, input logic [7:0] next_data);
        int  n;
        bit  e;
        n = 0;
        while (Tx_Busy && n < 300) begin
            if (n == 0 && !hold) begin
                Transmit_Start = 1'b0;
                Break_Req      = 1'b0;
            end
            if (n == cts_drop) CTS = 1'b0;
            if (n == 30) Tx_Data = ~Tx_Data;
            if (n == rearm_at) Transmit_Start = 1'b0;
            if (rearm_at >= 0 && n == rearm_at + 1) begin
                Transmit_Start = 1'b1;
                Tx_Data        = next_data;
            end
            if (n % int'(BD) == int'(BD / 2)) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b1;
                chk($sformatf("%s_bit%0d", nm, n / int'(BD)), 32'(Tx), 32'(e));
            end
            chk({nm, "_done_early"}, 32'(Tx_Done), 32'd0);
            n++;
            @(negedge SysClk);
        end
        chk({nm, "_busy_len"}, 32'(n), 32'(NB * BD));
        chk({nm, "_exp_left"}, 32'(exp_q.size()), 32'd0);
        chk({nm, "_done"}, 32'(Tx_Done), 32'd1);
        chk({nm, "_idle_tx"}, 32'(Tx), 32'd1);
        @(negedge SysClk);
        chk({nm, "_done_pulse"}, 32'(Tx_Done), 32'd0);
    endtask

    initial begin
        bit ok;

        vecs[0] = '{"a5",   8'hA5, 1'b0, 1'b0};
        vecs[1] = '{"07",   8'h07, 1'b0, 1'b1};
        vecs[2] = '{"ff",   8'hFF, 1'b0, 1'b0};
        vecs[3] = '{"00",   8'h00, 1'b0, 1'b0};
        vecs[4] = '{"80",   8'h80, 1'b0, 1'b1};
        vecs[5] = '{"brk",  8'hA5, 1'b1, 1'b0};

        Rst            = 1'b1;
        Tx_Data        = 8'h00;
        Transmit_Start = 1'b0;
        Break_Req      = 1'b0;
        CTS            = 1'b1;
        repeat (3) @(negedge SysClk);
        chk("rst_tx", 32'(Tx), 32'd1);
        chk("rst_busy", 32'(Tx_Busy), 32'd0);
        chk("rst_done", 32'(Tx_Done), 32'd0);
        Rst = 1'b0;
        repeat (2) @(negedge SysClk);

        for (int v = 0; v < 6; v++) begin
            push_frame(vecs[v].data, vecs[v].par, vecs[v].brk);
            start_req(vecs[v].name, vecs[v].data, vecs[v].brk);
            check_frame(vecs[v].name, 1'b0, -1, -1, 8'h00);
            repeat (3) @(negedge SysClk);
        end

        // Flow control: requests wait while CTS is low; CTS drop mid-frame is ignored.
        CTS            = 1'b0;
        Tx_Data        = 8'h6B;
        Transmit_Start = 1'b1;
        ok = 1'b1;
        repeat (100) begin
            @(negedge SysClk);
            if (Tx !== 1'b1 || Tx_Busy !== 1'b0) ok = 1'b0;
        end
        chk("cts_wait", 32'(ok), 32'd1);
        push_frame(8'h6B, 1'b1, 1'b0);
        CTS = 1'b1;
        @(negedge SysClk);
        chk("cts_go_busy", 32'(Tx_Busy), 32'd1);
        chk("cts_go_tx", 32'(Tx), 32'd0);
        check_frame("cts", 1'b0, 50, -1, 8'h00);
        CTS = 1'b1;
        repeat (3) @(negedge SysClk);

        // Held request with one-cycle re-arm mid-frame: back-to-back second frame.
        push_frame(8'h96, 1'b0, 1'b0);
        start_req("b2b1", 8'h96, 1'b0);
        check_frame("b2b1", 1'b1, -1, 100, 8'h3C);
        chk("b2b_gap_busy", 32'(Tx_Busy), 32'd1);
        chk("b2b_gap_tx", 32'(Tx), 32'd0);
        push_frame(8'h3C, 1'b0, 1'b0);
        check_frame("b2b2", 1'b1, -1, -1, 8'h00);
        ok = 1'b1;
        repeat (40) begin
            if (Tx_Busy !== 1'b0 || Tx !== 1'b1) ok = 1'b0;
            @(negedge SysClk);
        end
        chk("held_no_resend", 32'(ok), 32'd1);
        Transmit_Start = 1'b0;
        repeat (3) @(negedge SysClk);

        // Reset during data bit 3: asynchronous return to idle, no done pulse.
        start_req("rst_mid", 8'h5A, 1'b0);
        Transmit_Start = 1'b0;
        repeat (5 * BD + 8 - 1) @(negedge SysClk);
        Rst = 1'b1;
        #1;
        chk("rst_mid_tx", 32'(Tx), 32'd1);
        chk("rst_mid_busy", 32'(Tx_Busy), 32'd0);
        ok = 1'b1;
        repeat (3) begin
            @(negedge SysClk);
            if (Tx_Done !== 1'b0 || Tx !== 1'b1) ok = 1'b0;
        end
        Rst = 1'b0;
        repeat (40) begin
            @(negedge SysClk);
            if (Tx_Done !== 1'b0 || Tx_Busy !== 1'b0) ok = 1'b0;
        end
        chk("rst_mid_no_done", 32'(ok), 32'd1);
        exp_q.delete();
        push_frame(8'hFF, 1'b0, 1'b0);
        start_req("post_rst", 8'hFF, 1'b0);
        check_frame("post_rst", 1'b0, -1, -1, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
UART transmit path. Accepts a parallel data word and serializes it onto Tx as one frame: start bit, then data bits MSB first, then an optional parity bit, then stop bits. Bit timing comes from an internal baud divider on SysClk, so no separate baud clock is needed. The block also honours CTS flow control and can emit a timed break condition, which the receive side uses to detect breaks.

Parameters:
SYSCLK_RATE, 100000000, SysClk frequency in Hz
BAUD_RATE, 9600, line rate in bits/s; BAUD_DIV = SYSCLK_RATE/BAUD_RATE (integer divide, must be >= 2)
DATA_BITS, 8, data bits per frame
PARITY_BIT, 1, 1 = parity bit present, 0 = parity omitted
STOP_BITS, 2, number of stop bits (>= 1)

Ports:
SysClk  in  1  system clock; all logic on rising edge
Rst  in  1  reset, asynchronous, active-high
Tx_Data  in  DATA_BITS  word to send; sampled on the accept edge only
Transmit_Start  in  1  level request to send Tx_Data
Break_Req  in  1  level request to send a break
CTS  in  1  clear-to-send from the far end; high permits a new frame
Tx  out  1  serial line output; idles high
Tx_Busy  out  1  high from the cycle after accept until the frame ends
Tx_Done  out  1  one-cycle pulse after the final stop bit (or the final break bit)

Behaviour:
- One clock, SysClk. Reset is asynchronous and active-high.
- Reset values: Tx=1, Tx_Busy=0, Tx_Done=0, FSM=IDLE, baud counter=0, bit counter=0, armed=1.
- Reset asserted mid-frame: Tx returns to 1 immediately (asynchronously) and the frame is abandoned. No Tx_Done is produced.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
- Frame length TX_BITS = 1 + DATA_BITS + PARITY_BIT + STOP_BITS.
- Accept condition, evaluated in IDLE on a SysClk edge: armed=1, CTS=1, and (Transmit_Start=1 or Break_Req=1).
  - Break_Req has priority when both requests are high.
  - On accept: Tx_Data is latched into the shift register, armed clears, the baud counter clears, and the FSM goes to START (or BREAK).
  - Tx and Tx_Busy change on the accept edge itself: both are visible in the cycle after the sampling edge.
- Re-arm: armed sets on any cycle where Transmit_Start=0 and Break_Req=0. A request held high across the end of a frame therefore does not retransmit.
- Bit period: every bit lasts exactly BAUD_DIV SysClk cycles.
  - The baud counter counts 0..BAUD_DIV-1. A bit advances when the counter wraps.
  - Total frame duration is TX_BITS*BAUD_DIV cycles.
- Line values by state:
  - START: Tx=0.
  - DATA: Tx = shift register MSB; shift left at each bit end. Data goes out bit DATA_BITS-1 first.
  - PARITY: Tx = XOR of all latched data bits, so ones(data)+parity is even. State skipped when PARITY_BIT=0.
  - STOP: Tx=1 for STOP_BITS bit periods.
  - BREAK: Tx=0 for TX_BITS bit periods.
- Frame end: on the last cycle of the final stop bit (or the final break bit) the FSM returns to IDLE. In the following cycle Tx_Busy=0, Tx_Done=1 for exactly one cycle, and Tx=1.
- Earliest next accept is the cycle Tx_Done is high, provided the block has re-armed. Back-to-back frames therefore have zero idle bit time.
- CTS is sampled only at accept. CTS falling mid-frame does not truncate the frame. With CTS=0 in IDLE, requests wait and Tx stays 1.
- Changes to Tx_Data, Transmit_Start or Break_Req during a frame have no effect on that frame.
- Bit counter width is clog2(max(DATA_BITS, STOP_BITS, TX_BITS)+1). Baud counter width is clog2(BAUD_DIV).

Test Plan:
- Params: SYSCLK_RATE=16, BAUD_RATE=1, so BAUD_DIV=16; DATA_BITS=8; PARITY_BIT=1; STOP_BITS=2.
- Basic frame: CTS=1, Tx_Data=8'hA5, pulse Transmit_Start -> sampled Tx at bit centres = 0,1,0,1,0,0,1,0,1,0,1,1 (start, A5 MSB first, parity 0, stops). Tx_Busy high 192 cycles, then Tx_Done pulses once.
- Odd parity data: Tx_Data=8'h07 -> parity bit = 1; frame 0,00000111,1,1,1.
- Flow control: CTS=0, Transmit_Start held high 100 cycles -> Tx stays 1, Tx_Busy=0. Raise CTS -> frame starts on the next edge. Drop CTS mid-frame -> frame completes intact.
- Re-arm and back-to-back: hold Transmit_Start high through the whole frame -> exactly one frame sent. Drop it for 1 cycle, raise it with Tx_Data=8'h3C -> second frame starts with no idle gap beyond the re-arm cycle.
- Break: Break_Req and Transmit_Start both high -> Tx=0 for 192 cycles, then Tx=1 and Tx_Done pulses. Tx_Data is not sent.
- Reset mid-frame: assert Rst during data bit 3 -> Tx=1 and Tx_Busy=0 asynchronously, no Tx_Done. After release, a new frame with 8'hFF sends correctly (parity 0).
